memwb_skid_pipe: RTL and testbench

- Parametrised MEM/WB pipeline boundary: carries ALU result, memory read data, destination register and writeback controls from MEM to WB.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the stage runs at full throughput and in_ready never depends combinationally on out_ready.
- Adds a synchronous flush and suppression of writes to register 0.
- Sits between the data-memory stage and register-file write port.

---
 rtl/memwb_pkg.sv | 33 +++
 rtl/memwb_payload_reg.sv | 23 ++
 rtl/memwb_skid_pipe.sv | 131 +++++++++++++
 tb/tb_memwb_skid_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// memwb_pkg: state encoding and payload layout shared by
// the MEM/WB skid pipeline and its payload registers.
package memwb_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int PAYLOAD_W      = 2*DEF_DATA_W+DEF_REG_ADDR_W+2;

   // Packed layout, LSB first:
   // mem_to_reg, reg_write, dest, mem, alu
   localparam int OFF_M2R  = 0;
   localparam int OFF_RW   = 1;
   localparam int OFF_DEST = 2;

   function automatic int payload_w(int dw, int aw);
      return 2*dw + aw + 2;
   endfunction

   function automatic int off_mem(int aw);
      return OFF_DEST + aw;
   endfunction

   function automatic int off_alu(int dw, int aw);
      return OFF_DEST + aw + dw;
   endfunction

endpackage

// File: rtl/memwb_payload_reg.sv
// memwb_payload_reg: one packed MEM/WB entry with load
// enable; cleared only by the asynchronous reset.
module memwb_payload_reg
   import memwb_pkg::*;
#(
   parameter int W = PAYLOAD_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Hold the entry until a new one is loaded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/memwb_skid_pipe.sv
// memwb_skid_pipe: MEM/WB boundary with a 2-entry skid
// buffer and flush. Optional macro: MEMWB_WB_MUX_EN.
module memwb_skid_pipe
   import memwb_pkg::*;
#(
   parameter int DATA_W            = 32,
   parameter int REG_ADDR_W        = 5,
   parameter int ZERO_REG_SUPPRESS = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     alu_i,
   input  logic [DATA_W-1:0]     mem_i,
   input  logic [REG_ADDR_W-1:0] dest_i,
   input  logic                  reg_write_i,
   input  logic                  mem_to_reg_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     alu_o,
   output logic [DATA_W-1:0]     mem_o,
   output logic [REG_ADDR_W-1:0] dest_o,
   output logic                  reg_write_o,
   output logic                  mem_to_reg_o
`ifdef MEMWB_WB_MUX_EN
   ,
   output logic [DATA_W-1:0]     wb_data_o
`endif
);

   localparam int PW = payload_w(DATA_W, REG_ADDR_W);
   localparam int OM = off_mem(REG_ADDR_W);
   localparam int OA = off_alu(DATA_W, REG_ADDR_W);

   state_e          state;
   logic            accept;
   logic            pop;
   logic            load_main;
   logic            load_skid;
   logic            zero_hit;
   logic [PW-1:0]   in_pay;
   logic [PW-1:0]   main_d;
   logic [PW-1:0]   main_q;
   logic [PW-1:0]   skid_q;

   // Ready depends on registered state only, never on out_ready.
   assign in_ready  = (state != ST_TWO);
   assign out_valid = (state != ST_EMPTY);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign in_pay = {alu_i, mem_i, dest_i,
                    reg_write_i, mem_to_reg_i};

   // Route loads; flush suppresses every capture.
   always_comb begin
      load_main = 1'b0;
      load_skid = 1'b0;
      main_d    = in_pay;
      if (!flush) begin
         unique case (state)
            ST_EMPTY: load_main = accept;
            ST_ONE: begin
               load_main = accept & pop;
               load_skid = accept & ~pop;
            end
            ST_TWO: begin
               load_main = pop;
               main_d    = skid_q;
            end
            default: ;
         endcase
      end
   end

   // Occupancy FSM; flush empties both entries at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_EMPTY;
      else if (flush)
         state <= ST_EMPTY;
      else begin
         unique case (state)
            ST_EMPTY:
               if (accept) state <= ST_ONE;
            ST_ONE:
               if (accept & ~pop)
                  state <= ST_TWO;
               else if (~accept & pop)
                  state <= ST_EMPTY;
            ST_TWO:
               if (pop) state <= ST_ONE;
            default:
               state <= ST_EMPTY;
         endcase
      end
   end

   memwb_payload_reg #(.W(PW)) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (load_main),
      .d     (main_d),
      .q     (main_q)
   );

   memwb_payload_reg #(.W(PW)) u_skid (
      .clk   (clk),
      .reset (reset),
      .load  (load_skid),
      .d     (in_pay),
      .q     (skid_q)
   );

   assign alu_o        = main_q[OA +: DATA_W];
   assign mem_o        = main_q[OM +: DATA_W];
   assign dest_o       = main_q[OFF_DEST +: REG_ADDR_W];
   assign mem_to_reg_o = main_q[OFF_M2R];

   assign zero_hit    = (ZERO_REG_SUPPRESS != 0) &&
                        (dest_o == '0);
   assign reg_write_o = main_q[OFF_RW] & out_valid &
                        ~zero_hit;

`ifdef MEMWB_WB_MUX_EN
   assign wb_data_o = mem_to_reg_o ? mem_o : alu_o;
`endif

endmodule

// File: tb/tb_memwb_skid_pipe.sv
// tb_memwb_skid_pipe: scoreboard bench for the MEM/WB
// skid pipeline (stream, backpressure, flush, reset).
module tb_memwb_skid_pipe;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] mem;
      logic [4:0]  dest;
      logic        rw;
      logic        m2r;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_i;
   logic [31:0] mem_i;
   logic [4:0]  dest_i;
   logic        reg_write_i;
   logic        mem_to_reg_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_o;
   logic [31:0] mem_o;
   logic [4:0]  dest_o;
   logic        reg_write_o;
   logic        mem_to_reg_o;
`ifdef MEMWB_WB_MUX_EN
   logic [31:0] wb_data_o;
`endif

   int   errors = 0;
   int   checks = 0;
   ent_t q[$];

   always #5 clk = ~clk;

   memwb_skid_pipe dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .alu_i        (alu_i),
      .mem_i        (mem_i),
      .dest_i       (dest_i),
      .reg_write_i  (reg_write_i),
      .mem_to_reg_i (mem_to_reg_i),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .alu_o        (alu_o),
      .mem_o        (mem_o),
      .dest_o       (dest_o),
      .reg_write_o  (reg_write_o),
      .mem_to_reg_o (mem_to_reg_o)
`ifdef MEMWB_WB_MUX_EN
      ,
      .wb_data_o    (wb_data_o)
`endif
   );

   // Scoreboard: model occupancy, compare head on pop.
   always @(negedge clk) begin
      ent_t e;
      if (reset) begin
         q.delete();
      end else begin
         checks++;
         if (out_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL occ_valid: got %b want %b",
                     out_valid, q.size() != 0);
         end
         checks++;
         if (in_ready !== (q.size() < 2)) begin
            errors++;
            $display("FAIL occ_ready: got %b want %b",
                     in_ready, q.size() < 2);
         end
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready && q.size() > 0) begin
               e = q.pop_front();
               checks++;
               if (alu_o !== e.alu || mem_o !== e.mem ||
                   dest_o !== e.dest ||
                   mem_to_reg_o !== e.m2r ||
                   reg_write_o !== (e.rw && e.dest != 0)) begin
                  errors++;
                  $display("FAIL head: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
                           alu_o, mem_o, dest_o, reg_write_o,
                           mem_to_reg_o, e.alu, e.mem, e.dest,
                           e.rw && e.dest != 0, e.m2r);
               end
            end
            if (in_valid && in_ready)
               q.push_back({alu_i, mem_i, dest_i,
                            reg_write_i, mem_to_reg_i});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [31:0] a,
                      input logic [31:0] m, input logic [4:0] d,
                      input logic rw, input logic m2r);
      in_valid     = v;
      alu_i        = a;
      mem_i        = m;
      dest_i       = d;
      reg_write_i  = rw;
      mem_to_reg_i = m2r;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      out_ready = 1'b0;
      put(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      #12;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          alu_o !== 32'h0 || mem_o !== 32'h0 ||
          dest_o !== 5'd0 || reg_write_o !== 1'b0 ||
          mem_to_reg_o !== 1'b0) begin
         errors++;
         $display("FAIL reset: got v=%b r=%b a=%h m=%h d=%h rw=%b want 0 1 0 0 0 0",
                  out_valid, in_ready, alu_o, mem_o, dest_o,
                  reg_write_o);
      end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         put(1'b1, 32'h11 + i, 32'h100 + i, 5'(i + 1),
             1'b1, i[0]);
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready: got %b want 1", in_ready);
         end
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 ||
                alu_o !== 32'h11 + i - 1) begin
               errors++;
               $display("FAIL stream_out: got %b/%h want 1/%h",
                        out_valid, alu_o, 32'h11 + i - 1);
            end
         end
         step();
      end
      put(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || alu_o !== 32'h14) begin
         errors++;
         $display("FAIL stream_last: got %b/%h want 1/14",
                  out_valid, alu_o);
      end
      step();
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      put(1'b1, 32'hA0, 32'h0, 5'd3, 1'b1, 1'b0);
      step();
      put(1'b1, 32'hA1, 32'h1, 5'd3, 1'b1, 1'b0);
      step();
      out_ready = 1'b0;
      put(1'b1, 32'hA2, 32'h2, 5'd3, 1'b1, 1'b0);
      step();
      put(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          alu_o !== 32'hA1) begin
         errors++;
         $display("FAIL bp_two: got r=%b v=%b a=%h want 0 1 a1",
                  in_ready, out_valid, alu_o);
      end
      step();
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (alu_o !== 32'hA1) begin
         errors++;
         $display("FAIL bp_first: got %h want a1", alu_o);
      end
      step();
      @(negedge clk);
      checks++;
      if (alu_o !== 32'hA2 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_second: got %b/%h want 1/a2",
                  out_valid, alu_o);
      end
      step();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: got %b want 0", out_valid);
      end
      step();
   endtask

   task automatic test_zero_reg();
      out_ready = 1'b1;
      put(1'b1, 32'h50, 32'h0, 5'd0, 1'b1, 1'b0);
      step();
      put(1'b1, 32'h51, 32'h0, 5'd5, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (reg_write_o !== 1'b0 || dest_o !== 5'd0) begin
         errors++;
         $display("FAIL zero_reg: got rw=%b d=%h want 0 0",
                  reg_write_o, dest_o);
      end
      step();
      put(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (reg_write_o !== 1'b1 || dest_o !== 5'd5) begin
         errors++;
         $display("FAIL nonzero_reg: got rw=%b d=%h want 1 5",
                  reg_write_o, dest_o);
      end
      step();
      step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      put(1'b1, 32'hB0, 32'h0, 5'd2, 1'b1, 1'b0);
      step();
      put(1'b1, 32'hB1, 32'h0, 5'd2, 1'b1, 1'b0);
      step();
      flush = 1'b1;
      put(1'b1, 32'hFF, 32'hFF, 5'd2, 1'b1, 1'b0);
      step();
      flush = 1'b0;
      put(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          reg_write_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_two: got v=%b r=%b rw=%b want 0 1 0",
                  out_valid, in_ready, reg_write_o);
      end
      out_ready = 1'b1;
      step();
      put(1'b1, 32'hC0, 32'h0, 5'd4, 1'b1, 1'b0);
      out_ready = 1'b0;
      step();
      flush = 1'b1;
      put(1'b1, 32'hC1, 32'h0, 5'd4, 1'b1, 1'b0);
      step();
      flush = 1'b0;
      put(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_one: got %b/%h want 0",
                     out_valid, alu_o);
         end
         step();
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      put(1'b1, 32'hD0, 32'h55, 5'd7, 1'b1, 1'b1);
      step();
      put(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || reg_write_o !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got %b/%b want 1/1",
                  out_valid, reg_write_o);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || reg_write_o !== 1'b0 ||
          alu_o !== 32'h0 || mem_o !== 32'h0 ||
          dest_o !== 5'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: got v=%b rw=%b a=%h m=%h d=%h r=%b",
                  out_valid, reg_write_o, alu_o, mem_o, dest_o,
                  in_ready);
      end
      @(negedge clk);
      step();
      reset = 1'b0;
      step();
   endtask

`ifdef MEMWB_WB_MUX_EN
   task automatic test_wb_mux();
      out_ready = 1'b1;
      put(1'b1, 32'h1234, 32'hBEEF, 5'd6, 1'b1, 1'b1);
      step();
      put(1'b1, 32'h1234, 32'hBEEF, 5'd6, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (wb_data_o !== 32'hBEEF) begin
         errors++;
         $display("FAIL wb_mem: got %h want beef", wb_data_o);
      end
      step();
      put(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (wb_data_o !== 32'h1234) begin
         errors++;
         $display("FAIL wb_alu: got %h want 1234", wb_data_o);
      end
      step();
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_zero_reg();
      test_flush();
`ifdef MEMWB_WB_MUX_EN
      test_wb_mux();
`endif
      test_async_reset();
      step();
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
